// File: rtl/bit_serial_adder_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial adder.
// The master drives the request and operands; the slave (the adder) returns status and the result.
interface bit_serial_adder_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/bit_serial_adder.sv
// W-bit adder using one full-adder cell, one result bit per clock, LSB first.
// Handshake: start is accepted at an edge when busy=0 (IDLE or DONE); done pulses one cycle with sum/cout.
module bit_serial_adder #(
  parameter int W = 8
) (
   input  logic              clk,
   input  logic              rst,
   bit_serial_adder_if.slave bus,
   output logic [1:0]        dbg_state
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state;
   logic [W-1:0]  a_sr;
   logic [W-1:0]  b_sr;
   logic [W-1:0]  psum;
   logic [W-1:0]  psum_next;
   logic          carry;
   logic          s_bit;
   logic          c_next;
   logic [CW-1:0] cnt;
   logic          last_bit;

   // Full-adder cell; each new sum bit enters at the MSB so bit 0 lands at position 0 after W shifts.
   always_comb begin
      s_bit           = a_sr[0] ^ b_sr[0] ^ carry;
      c_next          = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
      psum_next       = psum >> 1;
      psum_next[W-1]  = s_bit;
      last_bit        = (cnt == CW'(W - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         a_sr     <= '0;
         b_sr     <= '0;
         psum     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.sum  <= '0;
         bus.cout <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  a_sr     <= bus.a;
                  b_sr     <= bus.b;
                  carry    <= bus.cin;
                  psum     <= '0;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= SHIFT;
               end else begin
                  state    <= IDLE;
               end
            end
            SHIFT: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               psum  <= psum_next;
               carry <= c_next;
               cnt   <= cnt + CW'(1);
               // start is deliberately not looked at here: an in-flight addition cannot be replaced.
               if (last_bit) begin
                  bus.sum  <= psum_next;
                  bus.cout <= c_next;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  state    <= DONE;
               end
            end
            default: begin
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Randomized and directed bench for bit_serial_adder (W=8 and W=1 instances) with a queue scoreboard.
module tb_bit_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit_serial_adder_if #(.W(8)) bus8 ();
  bit_serial_adder_if #(.W(1)) bus1 ();
  logic [1:0] dbg8;
  logic [1:0] dbg1;

  bit_serial_adder #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8), .dbg_state(dbg8));
  bit_serial_adder #(.W(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // res = {cout, sum}; acc = cycle index after the accepting edge; dn = cycle index where done is high
  typedef struct {
    logic [8:0] res;
    int         acc;
    int         dn;
  } exp_t;
  exp_t exp8_q[$];
  exp_t exp1_q[$];
  logic [8:0] last8 = '0;
  logic [1:0] last1 = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon8
    logic eb, ed;
    exp_t e;
    if (rst === 1'b0) begin
      eb = 1'b0;
      ed = 1'b0;
      if (exp8_q.size() > 0) begin
        eb = (exp8_q[0].acc <= cyc) && (cyc < exp8_q[0].dn);
        ed = (exp8_q[0].dn == cyc);
      end
      check("busy8", 32'(bus8.busy), 32'(eb));
      check("done8", 32'(bus8.done), 32'(ed));
      if (bus8.done && exp8_q.size() > 0) begin
        e = exp8_q.pop_front();
        check("result8", {23'b0, bus8.cout, bus8.sum}, {23'b0, e.res});
        last8 = e.res;
      end else begin
        check("hold8", {23'b0, bus8.cout, bus8.sum}, {23'b0, last8});
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic eb, ed;
    exp_t e;
    if (rst === 1'b0) begin
      eb = 1'b0;
      ed = 1'b0;
      if (exp1_q.size() > 0) begin
        eb = (exp1_q[0].acc <= cyc) && (cyc < exp1_q[0].dn);
        ed = (exp1_q[0].dn == cyc);
      end
      check("busy1", 32'(bus1.busy), 32'(eb));
      check("done1", 32'(bus1.done), 32'(ed));
      if (bus1.done && exp1_q.size() > 0) begin
        e = exp1_q.pop_front();
        check("result1", {30'b0, bus1.cout, bus1.sum}, {23'b0, e.res});
        last1 = e.res[1:0];
      end else begin
        check("hold1", {30'b0, bus1.cout, bus1.sum}, {30'b0, last1});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic timeout_fail(string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for busy=0", name);
  endtask

  task automatic wait_idle8();
    int n = 0;
    @(negedge clk);
    while (bus8.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus8.busy) timeout_fail("idle_wait8");
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    exp_t e;
    wait_idle8();
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = c;
    @(posedge clk);
    #1;
    e.res = {1'b0, a} + {1'b0, b} + 9'(c);
    e.acc = cyc;
    e.dn  = cyc + 8;
    exp8_q.push_back(e);
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.cin   = 1'($urandom);
  endtask

  task automatic op1(input logic a, input logic b, input logic c);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (bus1.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus1.busy) timeout_fail("idle_wait1");
    bus1.start = 1'b1;
    bus1.a     = a;
    bus1.b     = b;
    bus1.cin   = c;
    @(posedge clk);
    #1;
    e.res = 9'(2'(a) + 2'(b) + 2'(c));
    e.acc = cyc;
    e.dn  = cyc + 1;
    exp1_q.push_back(e);
    bus1.start = 1'b0;
    bus1.a     = 1'($urandom);
    bus1.b     = 1'($urandom);
    bus1.cin   = 1'($urandom);
  endtask

  // Request arriving mid-addition: must be ignored, no extra done.
  task automatic stray_start8(input logic [7:0] a, input logic [7:0] b);
    repeat (2) @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    repeat (2) @(negedge clk);
    bus8.start = 1'b0;
  endtask

  // start held high across two operations; operands changed during the first done cycle.
  task automatic back_to_back8();
    exp_t e;
    int   k;
    wait_idle8();
    bus8.start = 1'b1;
    bus8.a     = 8'h10;
    bus8.b     = 8'h20;
    bus8.cin   = 1'b0;
    @(posedge clk);
    #1;
    k = cyc;
    e.res = 9'h030;
    e.acc = k;
    e.dn  = k + 8;
    exp8_q.push_back(e);
    @(negedge clk);
    while (cyc < k + 8) @(negedge clk);
    bus8.a = 8'h7F;
    bus8.b = 8'h01;
    @(posedge clk);
    #1;
    e.res = 9'h080;
    e.acc = cyc;
    e.dn  = cyc + 8;
    exp8_q.push_back(e);
    bus8.start = 1'b0;
  endtask

  task automatic reset_midop();
    op8(8'hAA, 8'h55, 1'b1);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy",   32'(bus8.busy), 32'd0);
    check("rst_done",   32'(bus8.done), 32'd0);
    check("rst_result", {23'b0, bus8.cout, bus8.sum}, 32'd0);
    exp8_q.delete();
    exp1_q.delete();
    last8 = '0;
    last1 = '0;
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    #3;
    check("reset_busy8",   32'(bus8.busy), 32'd0);
    check("reset_done8",   32'(bus8.done), 32'd0);
    check("reset_result8", {23'b0, bus8.cout, bus8.sum}, 32'd0);
    check("reset_state8",  32'(dbg8), 32'd0);
    check("reset_result1", {30'b0, bus1.cout, bus1.sum}, 32'd0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;

    op8(8'h3C, 8'h5A, 1'b0);
    op8(8'hFF, 8'h01, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1);
    op8(8'h01, 8'h01, 1'b0);
    stray_start8(8'hF0, 8'h0F);
    back_to_back8();
    reset_midop();
    op8(8'h05, 8'h03, 1'b0);

    op1(1'b1, 1'b1, 1'b1);
    op1(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) stray_start8(8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 16; i++) begin
      op1(1'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    n = 0;
    while ((exp8_q.size() != 0 || exp1_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain8", 32'(exp8_q.size()), 32'd0);
    check("drain1", 32'(exp1_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
